ram_arbiter: RTL

Two-master arbiter that shares the single on-board RAM (behind the ram driver's STB/ACK handshake) between the CPU instruction-fetch port and the data-access port. It grants one master at a time, muxes that master's address, data and control onto the RAM side, and returns ACK and read data to the owner only. A watchdog aborts any transaction the RAM never acknowledges, so the pipeline cannot hang.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arb_watchdog.sv | 29 ++
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-master RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    typedef enum logic {
        M_I = 1'b0,
        M_D = 1'b1
    } master_e;

    localparam int TIMEOUT_DEF = 63;

endpackage

// File: rtl/ram_arb_watchdog.sv
// Serve-state cycle counter; flags expiry when a transaction has run TIMEOUT cycles.
module ram_arb_watchdog
    import ram_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic expire_o
);

    logic [7:0] cnt_q, cnt_d;

    // Count while busy, clear whenever idle so each grant starts from zero.
    always_comb begin
        cnt_d = '0;
        if (en_i) cnt_d = cnt_q + 8'd1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == 8'(TIMEOUT));

endmodule

// File: rtl/ram_arbiter.sv
// Two-master (instruction fetch / data) arbiter in front of the RAM driver.
// Alternating priority on contention, registered RAM-side request, combinational
// ack/rdata return to the owner, watchdog-forced error completion.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_stb,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_stb,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_sel,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                ram_stb,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_sel,
    input  logic                ram_ack,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                err,
    output logic                busy
);

    localparam int SEL_W = DATA_W / 8;

    state_e              state_q, state_d;
    master_e             last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                expire;

    ram_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q != IDLE),
        .expire_o (expire)
    );

    // Grant, completion and request-latch logic; acks only reach the current owner.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                // D wins contention unless it was the last one served.
                if (d_stb && (!i_stb || last_q == M_I)) begin
                    state_d = SERVE_D;
                    last_d  = M_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    sel_d   = d_sel;
                end else if (i_stb) begin
                    state_d = SERVE_I;
                    last_d  = M_I;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    sel_d   = '1;
                end
            end
            SERVE_I: begin
                if (!i_stb) begin
                    state_d = IDLE;  // abort: any ram_ack this cycle is dropped
                end else if (ram_ack) begin
                    i_ack   = 1'b1;
                    i_rdata = ram_rdata;
                    state_d = IDLE;
                end else if (expire) begin
                    i_ack   = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                if (!d_stb) begin
                    state_d = IDLE;
                end else if (ram_ack) begin
                    d_ack   = 1'b1;
                    d_rdata = ram_rdata;
                    state_d = IDLE;
                end else if (expire) begin
                    d_ack   = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, priority history and RAM-side request registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= M_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign ram_stb   = busy;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_sel   = sel_q;

endmodule
